meta_stream_serializer: RTL
===========================

// Module: meta_stream_serializer
// PURPOSE
//  Consumes the DW-bit metadata AXI-Stream produced by the metadata generator.
//  Serialises each word into DW/OW narrow beats, LSB slice first, and frames every
//  WORDS_PER_PKT input words as one output packet with tlast. Feeds the OW-bit
//  packet path toward the FIFO/DMA. Full AXI-Stream backpressure on both sides.
// PARAMETERS
//  DW             128  input word width; must equal the generator's DW
//  OW             32   output beat width; DW % OW == 0, OW >= 32
//  WORDS_PER_PKT  4    input words per output packet (>=1)
// PORTS
//  clk              in   1    rising-edge clock
//  resetn           in   1    asynchronous active-low reset
//  axis_in_tdata    in   DW   metadata word
//  axis_in_tvalid   in   1    input word valid
//  axis_in_tready   out  1    block accepts input word
//  axis_out_tdata   out  OW   output beat
//  axis_out_tvalid  out  1    output beat valid
//  axis_out_tready  in   1    downstream accepts beat
//  axis_out_tlast   out  1    last beat of packet
//  pkt_count        out  16   packets completed (wraps 0xFFFF->0)
// BEHAVIOUR
//  - Reset (async assert, sync release): out_tvalid=0, out_tlast=0, out_tdata=0,
//    in_tready=0 while resetn low, pkt_count=0, slice_cnt=0, word_cnt=0, state IDLE.
//  - RATIO=DW/OW. One DW-bit hold register; transfer = tvalid&tready same cycle.
//  - States: IDLE (empty, in_tready=1) -> SER on input transfer; SER drives
//    out_tdata=hold[slice_cnt*OW +: OW], out_tvalid=1.
//  - In SER, each output transfer: slice_cnt++. On slice RATIO-1 transfer:
//    slice_cnt=0, word_cnt++ (wraps at WORDS_PER_PKT); in_tready=1 combinationally
//    in that cycle so a new word loads back-to-back (no bubble); else -> IDLE.
//  - in_tready = (state==IDLE) | (out transfer on final slice). Never depends on in_tvalid.
//  - Latency: input transfer at cycle N -> first beat valid at N+1.
//  - tlast=1 exactly on slice RATIO-1 of word WORDS_PER_PKT-1; pkt_count++ on that transfer.
//  - out_tdata/out_tvalid/out_tlast held stable while tvalid&!tready (AXIS rule).
//  - Simultaneous final-slice accept and new input: both occur; next beat = slice 0 of new word.
//  - Upstream stall mid-packet: IDLE, word_cnt retained; packet resumes with next word.
//  - Reset mid-packet: packet truncated (no tlast emitted), counters cleared.
// CONFIGURATION
//  META_SEQ_HDR_EN defined: each packet begins with one header beat
//    {(OW-32)'0, 8'hA5, WORDS_PER_PKT[7:0], seq[15:0]}, state HDR entered from IDLE
//    when word_cnt==0 on input transfer, before slice 0; seq = pkt_count value;
//    packet = 1+WORDS_PER_PKT*RATIO beats; in_tready=0 during HDR.
//  Undefined: no header, no HDR state; packet = WORDS_PER_PKT*RATIO beats.
// STRUCTURE
//  - Package meta_pkg: state enum (IDLE, SER, HDR), header magic 8'hA5,
//    RATIO function/localparam, pkt_count width 16.
//  - Single module; no sub-module warranted (hold reg + two counters + FSM).
// TESTING
//  1 Reset: resetn=0 mid-packet -> all outputs 0 immediately; after release in_tready=1, pkt_count=0.
//  2 Stream 4 words 0x0F0E..00..0x3F..30 (DW=128), out_tready=1 -> 16 beats,
//    first beat 0x03020100, tlast only on beat 16, pkt_count=1, in_tready gapless.
//  3 out_tready toggled 1010.. -> beat data/tlast stable during stalls, order unchanged.
//  4 in_tvalid with 3-cycle gaps between words -> IDLE between words; tlast still on beat 16.
//  5 META_SEQ_HDR_EN: two packets -> headers 0xA5040000 then 0xA5040001; 17 beats each.
//  6 pkt_count preloaded via 65536 packets (fast sim, WORDS_PER_PKT=1, RATIO=4) -> wraps to 0.

Source files
------------

// File: rtl/meta_pkg.sv
// meta_pkg: shared types and constants for meta_stream_serializer.
package meta_pkg;
  typedef enum logic [1:0] {IDLE, SER, HDR} state_t;
  localparam logic [7:0] HDR_MAGIC = 8'hA5;
  localparam int CNT_W = 16;
  function automatic int ratio(int dw, int ow);
    return dw / ow;
  endfunction
endpackage

// File: rtl/meta_stream_serializer.sv
// meta_stream_serializer: DW-bit words to OW-bit beats, WORDS_PER_PKT words per tlast packet.
// Optional META_SEQ_HDR_EN prefixes each packet with a magic/length/sequence header beat.
module meta_stream_serializer
  import meta_pkg::*;
#(
  parameter int DW = 128,
  parameter int OW = 32,
  parameter int WORDS_PER_PKT = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [DW-1:0]    axis_in_tdata,
  input  logic             axis_in_tvalid,
  output logic             axis_in_tready,
  output logic [OW-1:0]    axis_out_tdata,
  output logic             axis_out_tvalid,
  input  logic             axis_out_tready,
  output logic             axis_out_tlast,
  output logic [CNT_W-1:0] pkt_count
);
  localparam int RATIO = ratio(DW, OW);
  localparam int SW = RATIO > 1 ? $clog2(RATIO) : 1;
  localparam int WW = WORDS_PER_PKT > 1 ? $clog2(WORDS_PER_PKT) : 1;
  state_t state;
  logic [DW-1:0] hold;
  logic [SW-1:0] slice_cnt;
  logic [WW-1:0] word_cnt;
  logic out_xfer, in_xfer, last_slice, last_word;
  logic [WW-1:0] word_nxt;
  assign out_xfer = axis_out_tvalid & axis_out_tready;
  assign last_slice = (state == SER) && (slice_cnt == SW'(RATIO - 1));
  assign last_word = word_cnt == WW'(WORDS_PER_PKT - 1);
  assign word_nxt = last_word ? '0 : word_cnt + 1'b1;
  // Final-slice acceptance reopens the input so a waiting word loads with no bubble.
  assign axis_in_tready = resetn & ((state == IDLE) | (out_xfer & last_slice));
  assign in_xfer = axis_in_tvalid & axis_in_tready;
  assign axis_out_tvalid = state != IDLE;
  assign axis_out_tlast = last_slice & last_word;
`ifdef META_SEQ_HDR_EN
  logic start_hdr;
  assign start_hdr = ((state == IDLE) ? word_cnt : word_nxt) == '0;
  assign axis_out_tdata = (state == SER) ? hold[int'(slice_cnt)*OW +: OW] :
                          (state == HDR) ? OW'({HDR_MAGIC, 8'(WORDS_PER_PKT), pkt_count}) : '0;
`else
  assign axis_out_tdata = (state == SER) ? hold[int'(slice_cnt)*OW +: OW] : '0;
`endif
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      hold <= '0;
      slice_cnt <= '0;
      word_cnt <= '0;
      pkt_count <= '0;
    end else begin
      if (in_xfer) hold <= axis_in_tdata;
      if (out_xfer && state == SER) begin
        slice_cnt <= last_slice ? '0 : slice_cnt + 1'b1;
        if (last_slice) word_cnt <= word_nxt;
        if (axis_out_tlast) pkt_count <= pkt_count + 1'b1;
      end
`ifdef META_SEQ_HDR_EN
      if (in_xfer) state <= start_hdr ? HDR : SER;
      else if (out_xfer && state == HDR) state <= SER;
      else if (out_xfer && last_slice) state <= IDLE;
`else
      if (in_xfer) state <= SER;
      else if (out_xfer && last_slice) state <= IDLE;
`endif
    end
  end
endmodule
